// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: RESET#, CKE, MRS x4 and ZQCL with programmable delays,
// then hands the pins to the controller by raising initDone.
module ddr3_init_seq #(
  parameter int          T_RESET  = 20000,
  parameter int          T_CKE    = 50000,
  parameter int          T_XPR    = 40,
  parameter int          T_MRD    = 4,
  parameter int          T_MOD    = 12,
  parameter int          T_ZQINIT = 512,
  parameter logic [13:0] MR0      = 14'h0000,
  parameter logic [13:0] MR1      = 14'h0000,
  parameter logic [13:0] MR2      = 14'h0000,
  parameter logic [13:0] MR3      = 14'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pllLocked,
  output logic        ddrResetN,
  output logic        ddrCke,
  output logic        ddrOdt,
  output logic        ddrCs,
  output logic        ddrRas,
  output logic        ddrCas,
  output logic        ddrWe,
  output logic [13:0] ddrAddr,
  output logic [2:0]  ddrBa,
  output logic        initDone,
  output logic [3:0]  initState
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, RST = 4'd1, CKE = 4'd2, XPR = 4'd3, MR2S = 4'd4,
    MR3S = 4'd5, MR1S = 4'd6, MR0S = 4'd7, ZQ = 4'd8, DONE = 4'd9
  } stateT;

  stateT       state, nextState;
  logic [16:0] count, nextCount;
  logic        entering;
  logic        nResetN, nCke;
  logic [3:0]  nCmd;
  logic [13:0] nAddr;
  logic [2:0]  nBa;

  // Counter is loaded with duration-1 so a state lasting N cycles exits when it reaches 0.
  function automatic logic [16:0] loadVal(input stateT s);
    case (s)
      RST:              loadVal = 17'(T_RESET - 1);
      CKE:              loadVal = 17'(T_CKE - 1);
      XPR:              loadVal = 17'(T_XPR - 1);
      MR2S, MR3S, MR1S: loadVal = 17'(T_MRD - 1);
      MR0S:             loadVal = 17'(T_MOD - 1);
      ZQ:               loadVal = 17'(T_ZQINIT - 1);
      default:          loadVal = 17'd0;
    endcase
  endfunction

  always_comb begin
    nextState = state;
    if (state == IDLE) begin
      if (pllLocked) nextState = RST;
    end else if (!pllLocked) begin
      nextState = IDLE;
    end else if (state != DONE && count == 17'd0) begin
      nextState = stateT'(state + 4'd1);
    end

    entering = (nextState != state);
    if (entering)              nextCount = loadVal(nextState);
    else if (count != 17'd0)   nextCount = count - 17'd1;
    else                       nextCount = count;

    // Pins are computed from the next state so they register alongside it.
    nResetN = (nextState != IDLE) && (nextState != RST);
    nCke    = (nextState >= XPR);
    nCmd    = 4'b0111;
    nAddr   = 14'd0;
    nBa     = 3'd0;
    if (!nResetN) begin
      nCmd = 4'b1111;
    end else if (entering) begin
      case (nextState)
        MR2S: begin nCmd = 4'b0000; nBa = 3'd2; nAddr = MR2; end
        MR3S: begin nCmd = 4'b0000; nBa = 3'd3; nAddr = MR3; end
        MR1S: begin nCmd = 4'b0000; nBa = 3'd1; nAddr = MR1; end
        MR0S: begin nCmd = 4'b0000; nBa = 3'd0; nAddr = MR0; end
        ZQ:   begin nCmd = 4'b0110; nAddr = 14'h0400; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 17'd0;
      ddrResetN <= 1'b0;
      ddrCke    <= 1'b0;
      ddrOdt    <= 1'b0;
      {ddrCs, ddrRas, ddrCas, ddrWe} <= 4'b1111;
      ddrAddr   <= 14'd0;
      ddrBa     <= 3'd0;
      initDone  <= 1'b0;
      initState <= 4'd0;
    end else begin
      state     <= nextState;
      count     <= nextCount;
      ddrResetN <= nResetN;
      ddrCke    <= nCke;
      ddrOdt    <= 1'b0;
      {ddrCs, ddrRas, ddrCas, ddrWe} <= nCmd;
      ddrAddr   <= nAddr;
      ddrBa     <= nBa;
      initDone  <= (nextState == DONE);
      initState <= nextState;
    end
  end

endmodule

// File: tb/tb_ddr3_init_seq.sv
// Directed bench for ddr3_init_seq: compares every output each cycle against a
// hand-derived event timeline for the small bench parameter set.
module tb_ddr3_init_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        pllLocked;
  logic        ddrResetN, ddrCke, ddrOdt, ddrCs, ddrRas, ddrCas, ddrWe;
  logic [13:0] ddrAddr;
  logic [2:0]  ddrBa;
  logic        initDone;
  logic [3:0]  initState;

  int checks = 0;
  int errors = 0;

  ddr3_init_seq #(
    .T_RESET(8), .T_CKE(10), .T_XPR(6), .T_MRD(4), .T_MOD(12), .T_ZQINIT(16),
    .MR0(14'h0520), .MR1(14'h0044), .MR2(14'h0008), .MR3(14'h0000)
  ) dut (
    .clock(clock), .reset(reset), .pllLocked(pllLocked),
    .ddrResetN(ddrResetN), .ddrCke(ddrCke), .ddrOdt(ddrOdt),
    .ddrCs(ddrCs), .ddrRas(ddrRas), .ddrCas(ddrCas), .ddrWe(ddrWe),
    .ddrAddr(ddrAddr), .ddrBa(ddrBa), .initDone(initDone), .initState(initState)
  );

  always #5 clock = ~clock;

  // Packed layout: state[28:25] done[24] rstN[23] cke[22] odt[21] cmd[20:17] ba[16:14] addr[13:0]
  logic [28:0] outVec;
  assign outVec = {initState, initDone, ddrResetN, ddrCke, ddrOdt,
                   ddrCs, ddrRas, ddrCas, ddrWe, ddrBa, ddrAddr};

  localparam logic [28:0] IDLE_VEC = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 3'd0, 14'd0};

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs t cycles after the first locked IDLE cycle.
  function automatic logic [28:0] expVec(input int t);
    logic [3:0]  st;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [13:0] addr;
    if      (t < 1)  st = 4'd0;
    else if (t < 9)  st = 4'd1;
    else if (t < 19) st = 4'd2;
    else if (t < 25) st = 4'd3;
    else if (t < 29) st = 4'd4;
    else if (t < 33) st = 4'd5;
    else if (t < 37) st = 4'd6;
    else if (t < 49) st = 4'd7;
    else if (t < 65) st = 4'd8;
    else             st = 4'd9;
    ba = 3'd0;
    addr = 14'd0;
    if (t < 9) cmd = 4'b1111;
    else       cmd = 4'b0111;
    case (t)
      25: begin cmd = 4'b0000; ba = 3'd2; addr = 14'h0008; end
      29: begin cmd = 4'b0000; ba = 3'd3; addr = 14'h0000; end
      33: begin cmd = 4'b0000; ba = 3'd1; addr = 14'h0044; end
      37: begin cmd = 4'b0000; ba = 3'd0; addr = 14'h0520; end
      49: begin cmd = 4'b0110; ba = 3'd0; addr = 14'h0400; end
      default: ;
    endcase
    expVec = {st, 1'(t >= 65), 1'(t >= 9), 1'(t >= 19), 1'b0, cmd, ba, addr};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic runTo(input string tag, input int t0, input int t1);
    for (int t = t0; t <= t1; t++) begin
      step();
      checkEq($sformatf("%s@%0d", tag, t), 32'(outVec), 32'(expVec(t)));
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    pllLocked = 1'b1;
    step(); step(); step();
    checkEq("resetVals", 32'(outVec), 32'(IDLE_VEC));

    // Nominal sequence, then 1-cycle lock drop at cycle 80 in DONE
    reset = 1'b0;
    checkEq("nom@0", 32'(outVec), 32'(expVec(0)));
    runTo("nom", 1, 80);
    pllLocked = 1'b0;
    step();
    checkEq("doneLoss81", 32'(outVec), 32'(IDLE_VEC));
    checkEq("doneLossInitDone", 32'(initDone), 32'd0);
    pllLocked = 1'b1;
    runTo("doneRelock", 1, 66);
    checkEq("doneRelockInitDone", 32'(initDone), 32'd1);

    // Lock loss during MR1
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkEq("mr1@0", 32'(outVec), 32'(expVec(0)));
    runTo("mr1", 1, 34);
    pllLocked = 1'b0;
    step();
    checkEq("mr1LossState", 32'(initState), 32'd0);
    checkEq("mr1LossCke", 32'(ddrCke), 32'd0);
    pllLocked = 1'b1;
    runTo("mr1Relock", 1, 70);

    // Delayed lock: 50 cycles unlocked after reset
    reset = 1'b1;
    pllLocked = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 1; i < 50; i++) begin
      step();
      checkEq($sformatf("noLock@%0d", i), 32'(outVec), 32'(IDLE_VEC));
    end
    pllLocked = 1'b1;
    runTo("delayed", 1, 70);

    // Reset mid-sequence at cycle 20 for 2 cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    runTo("pre", 1, 20);
    reset = 1'b1;
    step();
    checkEq("midReset21", 32'(outVec), 32'(IDLE_VEC));
    step();
    checkEq("midReset22", 32'(outVec), 32'(IDLE_VEC));
    reset = 1'b0;
    runTo("postReset", 1, 70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_init_seq.md
# ddr3_init_seq

DDR3 power-up initialization sequencer for the external DDR3 device. It owns the RESET#, CKE, ODT and command/address pins from PLL lock until the device is ready. It steps through the JEDEC reset, clock-enable, mode-register and ZQ-calibration sequence with programmable cycle counts, then raises `initDone` so the DDR controller's command path takes over the pins through its existing output mux. It runs in the DDR clock domain, at 100 MHz by default or 150 MHz when `jx2_cpu_ddrclock_150` is set.

## Interface
Parameters:
- `T_RESET`, 20000: cycles RESET# held low (200 us @ 100 MHz).
- `T_CKE`, 50000: cycles after RESET# release with CKE still low (500 us).
- `T_XPR`, 40: cycles after CKE high before the first MRS.
- `T_MRD`, 4: cycles from each MR2/MR3/MR1 command to the next command.
- `T_MOD`, 12: cycles from the MR0 command to ZQCL.
- `T_ZQINIT`, 512: cycles from ZQCL to `initDone`.
- `MR0`, `MR1`, `MR2`, `MR3`, 14'h0000 each: 14-bit mode-register payloads.

Ports:
- `clock`  in  1  DDR domain clock.
- `reset`  in  1  synchronous, active-high.
- `pllLocked`  in  1  PLL lock, already synchronized to `clock`.
- `ddrResetN`  out  1  DDR3 RESET# (active low).
- `ddrCke`  out  1  clock enable.
- `ddrOdt`  out  1  on-die termination.
- `ddrCs`  out  1  chip select (active low).
- `ddrRas`, `ddrCas`, `ddrWe`  out  1 each  command pins (active low).
- `ddrAddr`  out  14  address.
- `ddrBa`  out  3  bank address.
- `initDone`  out  1  sequence complete; the controller owns the pins.
- `initState`  out  4  current state encoding, for debug status.

## Operation
- States and encodings: IDLE=0, RST=1, CKE=2, XPR=3, MR2=4, MR3=5, MR1=6, MR0=7, ZQ=8, DONE=9.
- IDLE: exits to RST on the first cycle `pllLocked` is sampled high.
- Each timed state loads a 17-bit down-counter on entry and lasts exactly its parameter's number of cycles:
  - RST: `T_RESET`
  - CKE: `T_CKE`
  - XPR: `T_XPR`
  - MR2, MR3, MR1: `T_MRD` each
  - MR0: `T_MOD`
  - ZQ: `T_ZQINIT`
- States advance in the encoding order: RST, CKE, XPR, MR2, MR3, MR1, MR0, ZQ, then DONE.
- Every parameter must be at least 1. A value of 1 means a single-cycle state.
- DONE is terminal while `pllLocked` stays high.

Pin behaviour by state:
- `ddrResetN`: 0 in IDLE and RST; 1 in all later states.
- `ddrCke`: 0 in IDLE, RST and CKE; 1 from XPR onward.
- `ddrOdt`: always 0.

Command encoding as {Cs,Ras,Cas,We}:
- NOP = 0111.
- MRS = 0000.
- ZQCL = 0110, with `ddrAddr[10]`=1 and all other addr/ba bits 0.
- In IDLE and RST, Cs=1 (deselect).

Command issue:
- The MRS or ZQCL command is driven only on the first cycle of its state. Every other cycle drives NOP with addr=0 and ba=0.
- MRS uses `ddrBa` = register index (MR2: 3'd2, MR3: 3'd3, MR1: 3'd1, MR0: 3'd0) and `ddrAddr` = the matching MRx parameter.
- In DONE the block drives NOP continuously; the controller ignores these pins once `initDone`=1.

Lock loss:
- If `pllLocked` is sampled low in any state other than IDLE, the next state is IDLE. The full sequence restarts, including DONE → IDLE.
- `initDone` drops on the same edge.

## Timing
- All outputs are registered and change only on `posedge clock`.
- Reset values:
  - state = IDLE, counter = 0.
  - `ddrResetN`=0, `ddrCke`=0, `ddrOdt`=0.
  - {Cs,Ras,Cas,We} = 1111, `ddrAddr`=0, `ddrBa`=0.
  - `initDone`=0, `initState`=0.
- `reset` asserted mid-sequence returns to the reset values on the next edge, regardless of `pllLocked`.
- Outputs reflect the state registered on the same edge; no combinational path from `pllLocked` to any pin.
- Let cycle 0 be the first cycle in IDLE with `pllLocked`=1. Then:
  - RST begins at cycle 1.
  - `initDone` rises at cycle 1 + T_RESET + T_CKE + T_XPR + 3·T_MRD + T_MOD + T_ZQINIT.
- When `reset` and a lock drop occur in the same cycle, `reset` takes priority; the result is identical, so no conflict.

## Test plan
All scenarios use the bench parameters T_RESET=8, T_CKE=10, T_XPR=6, T_MRD=4, T_MOD=12, T_ZQINIT=16, MR0=14'h0520, MR1=14'h0044, MR2=14'h0008, MR3=14'h0000.

- **Nominal sequence.** Release `reset` with `pllLocked`=1 throughout. Require:
  - `ddrResetN` rises at cycle 9.
  - `ddrCke` rises at cycle 19.
  - MRS commands at cycles 25 (ba=2, addr=0x008), 29 (ba=3, addr=0x000), 33 (ba=1, addr=0x044) and 37 (ba=0, addr=0x520).
  - ZQCL at cycle 49 with addr=0x400.
  - `initDone`=1 at cycle 65.
- **Delayed lock.** Hold `pllLocked`=0 for 50 cycles after reset, then raise it. Require:
  - Block stays in IDLE with `ddrResetN`=0 and Cs=1 while lock is low.
  - All event times equal the nominal ones offset by +50.
- **Lock loss during MR1.** Drop `pllLocked` at cycle 34. Require:
  - `initState`=0 and `ddrCke`=0 at cycle 35.
  - After relock, the full sequence replays with nominal relative timing.
- **Lock loss in DONE.** Drop `pllLocked` for 1 cycle at cycle 80. Require:
  - `initDone`=0 at cycle 81.
  - `initDone` re-asserts 65 cycles after relock.
- **Reset mid-sequence.** Assert `reset` at cycle 20 for 2 cycles. Require:
  - Every output at its reset value by cycle 21.
  - Restart from IDLE after release.
- **Command hygiene.** In every non-command cycle from cycle 19 to cycle 65, require {Cs,Ras,Cas,We}=0111, addr=0 and ba=0; `ddrOdt`=0 throughout.
